// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : disp_pkg
// Brief    : Shared display constants and channel-select width helper.
// Revision : 1.0 - initial release
// ============================================================================
package disp_pkg;

    localparam logic [31:0] c_def_rst_data  = 32'hAA5555AA;
    localparam logic        c_blink_rst_bit = 1'b1;
    localparam logic        c_point_rst_bit = 1'b0;

    // Select width for a channel count; a single channel still gets one bit.
    function automatic int sw_of(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/disp_chan_scan_if.sv
`default_nettype none
// ============================================================================
// Module   : disp_chan_scan_if
// Brief    : Source-selector bus: channel data, controls and selected outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface disp_chan_scan_if
    import disp_pkg::*;
#(
    parameter int CH = 8,
    parameter int DW = 32,
    parameter int PW = 8
) ();
    localparam int SW = sw_of(CH);

    logic             EN;
    logic             auto;
    logic             freeze;
    logic [SW-1:0]    sel;
    logic [CH*DW-1:0] data_in;
    logic [CH*PW-1:0] les_in;
    logic [CH*PW-1:0] point_in;
    logic [DW-1:0]    disp_num;
    logic [PW-1:0]    le_out;
    logic [PW-1:0]    point_out;
    logic [SW-1:0]    cur_ch;
    logic             step;

    modport master (
        output EN, auto, freeze, sel, data_in, les_in, point_in,
        input  disp_num, le_out, point_out, cur_ch, step
    );

    modport slave (
        input  EN, auto, freeze, sel, data_in, les_in, point_in,
        output disp_num, le_out, point_out, cur_ch, step
    );
endinterface
`default_nettype wire

// File: rtl/scan_timer.sv
`default_nettype none
// ============================================================================
// Module   : scan_timer
// Brief    : Dwell counter, current-channel register and auto-scan step pulse.
// Revision : 1.0 - initial release
// ============================================================================
module scan_timer
    import disp_pkg::*;
#(
    parameter int CH    = 8,
    parameter int DWELL = 25_000_000
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 auto,
    input  wire logic                 freeze,
    input  wire logic [sw_of(CH)-1:0] sel,
    output logic      [sw_of(CH)-1:0] cur_ch,
    output logic                      step
);
    localparam int            SW      = sw_of(CH);
    localparam int            CW      = $clog2(DWELL);
    localparam logic [CW-1:0] c_last  = CW'(DWELL - 1);

    logic [CW-1:0] r_cnt;
    logic [SW-1:0] r_cur_ch;
    logic          r_step;

    // Freeze holds counter and channel so a resumed scan neither skips nor repeats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_cur_ch <= '0;
            r_step   <= 1'b0;
        end else if (freeze) begin
            r_step   <= 1'b0;
        end else if (auto) begin
            if (r_cnt == c_last) begin
                r_cnt    <= '0;
                r_cur_ch <= r_cur_ch + SW'(1);
                r_step   <= 1'b1;
            end else begin
                r_cnt    <= r_cnt + CW'(1);
                r_step   <= 1'b0;
            end
        end else begin
            r_cnt    <= '0;
            r_cur_ch <= sel;
            r_step   <= 1'b0;
        end
    end

    assign cur_ch = r_cur_ch;
    assign step   = r_step;
endmodule
`default_nettype wire

// File: rtl/disp_chan_scan.sv
`default_nettype none
// ============================================================================
// Module   : disp_chan_scan
// Brief    : N-channel registered display source selector with auto-scan.
// Revision : 1.0 - initial release
// ============================================================================
module disp_chan_scan
    import disp_pkg::*;
#(
    parameter int            CH       = 8,
    parameter int            DW       = 32,
    parameter int            PW       = 8,
    parameter int            DWELL    = 25_000_000,
    parameter logic [DW-1:0] RST_DATA = c_def_rst_data
) (
    input  wire logic          clk,
    input  wire logic          rst,
    disp_chan_scan_if.slave    bus
);
    localparam int SW = sw_of(CH);

    logic [DW-1:0] r_sh_data;
    logic [PW-1:0] r_sh_les;
    logic [PW-1:0] r_sh_pt;
    logic [DW-1:0] r_disp_num;
    logic [PW-1:0] r_le_out;
    logic [PW-1:0] r_point_out;
    logic [SW-1:0] w_cur_ch;
    logic          w_step;
    logic [DW-1:0] w_data_arr [CH];
    logic [PW-1:0] w_les_arr  [CH];
    logic [PW-1:0] w_pt_arr   [CH];

    scan_timer #(
        .CH    (CH),
        .DWELL (DWELL)
    ) u_scan_timer (
        .clk    (clk),
        .rst    (rst),
        .auto   (bus.auto),
        .freeze (bus.freeze),
        .sel    (bus.sel),
        .cur_ch (w_cur_ch),
        .step   (w_step)
    );

    // Shadow load ignores freeze so the CPU can stage a value while frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh_data <= RST_DATA;
            r_sh_les  <= {PW{c_blink_rst_bit}};
            r_sh_pt   <= {PW{c_point_rst_bit}};
        end else if (bus.EN) begin
            r_sh_data <= bus.data_in[0 +: DW];
            r_sh_les  <= bus.les_in[0 +: PW];
            r_sh_pt   <= bus.point_in[0 +: PW];
        end
    end

    generate
        for (genvar k = 0; k < CH; k++) begin : g_slice
            if (k == 0) begin : g_shadow
                assign w_data_arr[k] = r_sh_data;
                assign w_les_arr[k]  = r_sh_les;
                assign w_pt_arr[k]   = r_sh_pt;
            end else begin : g_direct
                assign w_data_arr[k] = bus.data_in[k*DW +: DW];
                assign w_les_arr[k]  = bus.les_in[k*PW +: PW];
                assign w_pt_arr[k]   = bus.point_in[k*PW +: PW];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_disp_num  <= RST_DATA;
            r_le_out    <= {PW{c_blink_rst_bit}};
            r_point_out <= {PW{c_point_rst_bit}};
        end else if (!bus.freeze) begin
            r_disp_num  <= w_data_arr[w_cur_ch];
            r_le_out    <= w_les_arr[w_cur_ch];
            r_point_out <= w_pt_arr[w_cur_ch];
        end
    end

    assign bus.disp_num  = r_disp_num;
    assign bus.le_out    = r_le_out;
    assign bus.point_out = r_point_out;
    assign bus.cur_ch    = w_cur_ch;
    assign bus.step      = w_step;
endmodule
`default_nettype wire
